// File: rtl/tag_ram_lookup_ctrl_pkg.sv
// Shared encodings for the tag RAM lookup controller: MSI states, op codes, FSM states.
// Optional statistics counters are enabled with LOOKUP_STATS_EN.
`timescale 1ns/1ps
package tag_ram_lookup_ctrl_pkg;

   localparam logic [1:0] ST_I = 2'b00;
   localparam logic [1:0] ST_S = 2'b01;
   localparam logic [1:0] ST_M = 2'b10;

   localparam logic [1:0] OP_LOOKUP = 2'b00;
   localparam logic [1:0] OP_UPDATE = 2'b01;
   localparam logic [1:0] OP_FILL   = 2'b10;

   typedef enum logic [2:0] {
      FSM_IDLE  = 3'd0,
      FSM_READ  = 3'd1,
      FSM_CMP   = 3'd2,
      FSM_WRITE = 3'd3,
      FSM_RESP  = 3'd4
   } fsm_e;

   // The unused encoding 11 is treated as Invalid everywhere.
   function automatic logic [1:0] norm_state(input logic [1:0] st);
      norm_state = (st == 2'b11) ? ST_I : st;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/tag_ram_lookup_ctrl_tag_compare.sv
// Combinational tag/state compare of a stored tag RAM word against the requested tag.
// Used by tag_ram_lookup_ctrl (LOOKUP_STATS_EN does not affect this block).
`timescale 1ns/1ps
module tag_compare
   import tag_ram_lookup_ctrl_pkg::*;
#(
   parameter int TWIDTH = 9
) (
   input  logic [TWIDTH+1:0] stored_i,
   input  logic [TWIDTH-1:0] tag_i,
   output logic              hit_o,
   output logic [1:0]        state_o,
   output logic [TWIDTH-1:0] tag_o
);

   logic [1:0] st_s;

   assign st_s    = norm_state(stored_i[1:0]);
   assign tag_o   = stored_i[TWIDTH+1:2];
   assign state_o = st_s;
   assign hit_o   = (tag_o == tag_i) && ((st_s == ST_S) || (st_s == ST_M));

endmodule

// File: rtl/tag_ram_lookup_ctrl.sv
// Initiator side of a sync-read tag RAM: lookup/update/fill sequencing with registered outputs.
// Define LOOKUP_STATS_EN to add saturating hit_count/miss_count outputs.
`timescale 1ns/1ps
module tag_ram_lookup_ctrl
   import tag_ram_lookup_ctrl_pkg::*;
#(
   parameter  int AWIDTH = 3,
   parameter  int TWIDTH = 9,
   localparam int DWIDTH = TWIDTH + 2
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [AWIDTH-1:0] req_index,
   input  logic [TWIDTH-1:0] req_tag,
   input  logic [1:0]        req_state,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_hit,
   output logic [1:0]        rsp_state,
   output logic [TWIDTH-1:0] rsp_tag,
   output logic [AWIDTH-1:0] ram_addr,
   output logic [DWIDTH-1:0] ram_din,
   output logic              ram_we,
`ifdef LOOKUP_STATS_EN
   output logic [15:0]       hit_count,
   output logic [15:0]       miss_count,
`endif
   input  logic [DWIDTH-1:0] ram_dout
);

   fsm_e              fsm_q;
   logic [1:0]        op_q;
   logic [AWIDTH-1:0] index_q;
   logic [TWIDTH-1:0] tag_q;
   logic [1:0]        state_q;
   logic              req_ready_q;
   logic              rsp_valid_q;
   logic              rsp_hit_q;
   logic [1:0]        rsp_state_q;
   logic [TWIDTH-1:0] rsp_tag_q;
   logic [DWIDTH-1:0] ram_din_q;
   logic              ram_we_q;

   logic              cmp_hit_s;
   logic [1:0]        cmp_state_s;
   logic [TWIDTH-1:0] cmp_tag_s;

   tag_compare #(.TWIDTH(TWIDTH)) u_cmp (
      .stored_i (ram_dout),
      .tag_i    (tag_q),
      .hit_o    (cmp_hit_s),
      .state_o  (cmp_state_s),
      .tag_o    (cmp_tag_s)
   );

`ifdef LOOKUP_STATS_EN
   logic [15:0] hit_cnt_q;
   logic [15:0] miss_cnt_q;

   // Only LOOKUP/UPDATE pass through CMP, so FILL is never counted.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hit_cnt_q  <= 16'd0;
         miss_cnt_q <= 16'd0;
      end else if (fsm_q == FSM_CMP) begin
         if (cmp_hit_s) begin
            hit_cnt_q <= sat_inc16(hit_cnt_q);
         end else begin
            miss_cnt_q <= sat_inc16(miss_cnt_q);
         end
      end else begin
         hit_cnt_q  <= hit_cnt_q;
         miss_cnt_q <= miss_cnt_q;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif

   // Request sequencing FSM; every output is a register updated here.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fsm_q       <= FSM_IDLE;
         op_q        <= OP_LOOKUP;
         index_q     <= {AWIDTH{1'b0}};
         tag_q       <= {TWIDTH{1'b0}};
         state_q     <= ST_I;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_hit_q   <= 1'b0;
         rsp_state_q <= 2'b00;
         rsp_tag_q   <= {TWIDTH{1'b0}};
         ram_din_q   <= {DWIDTH{1'b0}};
         ram_we_q    <= 1'b0;
      end else begin
         case (fsm_q)
            FSM_IDLE: begin
               if (req_valid) begin
                  op_q        <= (req_op == OP_FILL || req_op == OP_UPDATE) ? req_op : OP_LOOKUP;
                  index_q     <= req_index;
                  tag_q       <= req_tag;
                  state_q     <= norm_state(req_state);
                  req_ready_q <= 1'b0;
                  rsp_hit_q   <= 1'b0;
                  rsp_state_q <= 2'b00;
                  rsp_tag_q   <= {TWIDTH{1'b0}};
                  if (req_op == OP_FILL) begin
                     ram_din_q <= {req_tag, norm_state(req_state)};
                     ram_we_q  <= 1'b1;
                     fsm_q     <= FSM_WRITE;
                  end else begin
                     fsm_q     <= FSM_READ;
                  end
               end else begin
                  fsm_q <= FSM_IDLE;
               end
            end
            FSM_READ: begin
               fsm_q <= FSM_CMP;
            end
            FSM_CMP: begin
               rsp_hit_q   <= cmp_hit_s;
               rsp_state_q <= cmp_state_s;
               rsp_tag_q   <= cmp_tag_s;
               if (op_q == OP_UPDATE && cmp_hit_s) begin
                  ram_din_q <= {cmp_tag_s, state_q};
                  ram_we_q  <= 1'b1;
                  fsm_q     <= FSM_WRITE;
               end else begin
                  rsp_valid_q <= 1'b1;
                  fsm_q       <= FSM_RESP;
               end
            end
            FSM_WRITE: begin
               ram_we_q    <= 1'b0;
               rsp_valid_q <= 1'b1;
               fsm_q       <= FSM_RESP;
            end
            FSM_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  fsm_q       <= FSM_IDLE;
               end else begin
                  fsm_q <= FSM_RESP;
               end
            end
            default: begin
               ram_we_q    <= 1'b0;
               rsp_valid_q <= 1'b0;
               req_ready_q <= 1'b1;
               fsm_q       <= FSM_IDLE;
            end
         endcase
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_hit   = rsp_hit_q;
   assign rsp_state = rsp_state_q;
   assign rsp_tag   = rsp_tag_q;
   assign ram_addr  = index_q;
   assign ram_din   = ram_din_q;
   assign ram_we    = ram_we_q;

endmodule
